// File: rtl/text_renderer_pkg.sv
// Shared constants and pipeline types for the text-mode renderer.
// Font address widths are shared with char_rom.
package text_renderer_pkg;

    localparam int unsigned FONT_W      = 8;
    localparam int unsigned FONT_H      = 8;
    localparam int unsigned RGB_W       = 12;
    localparam int unsigned FONT_CODE_W = 7;
    localparam int unsigned FONT_ROW_W  = 3;
    localparam int unsigned FONT_AW     = FONT_CODE_W + FONT_ROW_W;
    localparam int unsigned ATTR_INV    = 7;
    localparam int unsigned ASCII_MSB   = 6;

    typedef struct packed {
        logic [FONT_W-1:0]     font;
        logic                  inv;
        logic [FONT_ROW_W-1:0] x_lo;
        logic                  cursor;
        logic                  video;
        logic                  hsync;
        logic                  vsync;
    } s2_t;

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port synchronous RAM, read-first on same-address collisions.
// Out-of-range writes are dropped; out-of-range reads return zero.
module text_buffer_ram #(
    parameter int unsigned DEPTH = 4800,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we && (32'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (32'(i_raddr) < DEPTH) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel generator: character buffer lookup, font ROM addressing
// and pixel serialization with a fixed 3-cycle latency; syncs delayed to match.
module text_renderer
    import text_renderer_pkg::*;
#(
    parameter int unsigned     COLS       = 80,
    parameter int unsigned     ROWS       = 60,
    parameter int unsigned     CNT_W      = 10,
    parameter int unsigned     BUF_AW     = 13,
    parameter logic [RGB_W-1:0] FG_RGB    = 12'hFFF,
    parameter logic [RGB_W-1:0] BG_RGB    = 12'h000,
    parameter int unsigned     BLINK_BITS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   h_count,
    input  logic [CNT_W-1:0]   v_count,
    input  logic               video_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               buf_we,
    input  logic [BUF_AW-1:0]  buf_waddr,
    input  logic [7:0]         buf_wdata,
    input  logic               cursor_en,
    input  logic [6:0]         cursor_col,
    input  logic [5:0]         cursor_row,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [FONT_W-1:0]  font_data,
    output logic [RGB_W-1:0]   rgb,
    output logic               hsync,
    output logic               vsync
);

    localparam int unsigned CW = CNT_W - FONT_ROW_W;

    logic [CW-1:0]     w_col;
    logic [CW-1:0]     w_row;
    logic [BUF_AW-1:0] w_rd_addr;
    logic              w_in_range;
    logic [7:0]        w_char;
    logic              w_cursor_hit;
    logic              w_bit;

    logic [FONT_ROW_W-1:0] r_s1_xlo;
    logic [FONT_ROW_W-1:0] r_s1_ylo;
    logic [CW-1:0]         r_s1_col;
    logic [CW-1:0]         r_s1_row;
    logic                  r_s1_video;
    logic                  r_s1_hs;
    logic                  r_s1_vs;
    s2_t                   r_s2;
    logic [BLINK_BITS-1:0] r_blink;
    logic [RGB_W-1:0]      r_rgb;
    logic                  r_hsync;
    logic                  r_vsync;

    assign w_col      = h_count[CNT_W-1:FONT_ROW_W];
    assign w_row      = v_count[CNT_W-1:FONT_ROW_W];
    assign w_rd_addr  = BUF_AW'(w_row) * BUF_AW'(COLS) + BUF_AW'(w_col);
    assign w_in_range = (h_count < CNT_W'(COLS * FONT_W)) &&
                        (v_count < CNT_W'(ROWS * FONT_H));

    text_buffer_ram #(
        .DEPTH (COLS * ROWS),
        .DW    (8),
        .AW    (BUF_AW)
    ) u_text_buffer_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (buf_we),
        .i_waddr (buf_waddr),
        .i_wdata (buf_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_char)
    );

    assign font_addr = {w_char[ASCII_MSB:0], r_s1_ylo};

    // Cursor underline sits on the last font row and shows during blink phase 0.
    assign w_cursor_hit = cursor_en &&
                          (32'(cursor_col) < COLS) && (32'(cursor_row) < ROWS) &&
                          (r_s1_col == CW'(cursor_col)) &&
                          (r_s1_row == CW'(cursor_row)) &&
                          (&r_s1_ylo) && !r_blink[BLINK_BITS-1];

    assign w_bit = r_s2.font[FONT_ROW_W'(FONT_W - 1) - r_s2.x_lo] ^ r_s2.inv ^ r_s2.cursor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_xlo   <= '0;
            r_s1_ylo   <= '0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_s1_video <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s2       <= '0;
            r_blink    <= '0;
            r_rgb      <= '0;
            r_hsync    <= 1'b0;
            r_vsync    <= 1'b0;
        end else begin
            if (h_count == '0 && v_count == '0) begin
                r_blink <= r_blink + 1'b1;
            end

            r_s1_xlo   <= h_count[FONT_ROW_W-1:0];
            r_s1_ylo   <= v_count[FONT_ROW_W-1:0];
            r_s1_col   <= w_col;
            r_s1_row   <= w_row;
            r_s1_video <= video_on && w_in_range;
            r_s1_hs    <= hsync_in;
            r_s1_vs    <= vsync_in;

            r_s2.font   <= font_data;
            r_s2.inv    <= w_char[ATTR_INV];
            r_s2.x_lo   <= r_s1_xlo;
            r_s2.cursor <= w_cursor_hit;
            r_s2.video  <= r_s1_video;
            r_s2.hsync  <= r_s1_hs;
            r_s2.vsync  <= r_s1_vs;

            r_rgb   <= r_s2.video ? (w_bit ? FG_RGB : BG_RGB) : '0;
            r_hsync <= r_s2.hsync;
            r_vsync <= r_s2.vsync;
        end
    end

    assign rgb   = r_rgb;
    assign hsync = r_hsync;
    assign vsync = r_vsync;

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer with a small font ROM stub driving font_data.
module tb_text_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        buf_we;
    logic [12:0] buf_waddr;
    logic [7:0]  buf_wdata;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [9:0]  font_addr;
    logic [7:0]  font_data;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    text_renderer #(
        .COLS       (80),
        .ROWS       (60),
        .CNT_W      (10),
        .BUF_AW     (13),
        .FG_RGB     (12'hFFF),
        .BG_RGB     (12'h000),
        .BLINK_BITS (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_count    (h_count),
        .v_count    (v_count),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .buf_we     (buf_we),
        .buf_waddr  (buf_waddr),
        .buf_wdata  (buf_wdata),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    // 'A' row 3 = 0x66, 'B' row 3 = 0x7C; other rows get an address-derived pattern.
    function automatic logic [7:0] rom(input logic [9:0] a);
        logic [7:0] r;
        case (a)
            10'h20B: r = 8'h66;
            10'h213: r = 8'h7C;
            default: r = a[7:0] ^ {a[2:0], a[9:5]};
        endcase
        return r;
    endfunction

    assign font_data = rom(font_addr);

    function automatic logic [11:0] pix(input logic [7:0] ch, input int x, input int y, input logic cur);
        logic [7:0] r;
        logic       b;
        r = rom({ch[6:0], 3'(y)});
        b = r[7 - x] ^ ch[7] ^ cur;
        return b ? 12'hFFF : 12'h000;
    endfunction

    task automatic apply(input int h, input int v, input logic von, input logic hs, input logic vs);
        h_count  = 10'(h);
        v_count  = 10'(v);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    task automatic idle();
        apply(700, 500, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write_buf(input int a, input logic [7:0] d);
        buf_waddr = 13'(a);
        buf_wdata = d;
        buf_we    = 1'b1;
        @(posedge clk); #1;
        buf_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        buf_we     = 1'b0;
        buf_waddr  = '0;
        buf_wdata  = '0;
        cursor_en  = 1'b0;
        cursor_col = '0;
        cursor_row = '0;
        idle();
        #2;
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", rgb); end
        total++; if (hsync !== 1'b0) begin bad++; $display("FAIL reset_hsync got=%b want=0", hsync); end
        total++; if (vsync !== 1'b0) begin bad++; $display("FAIL reset_vsync got=%b want=0", vsync); end
        total++; if (font_addr !== 10'h000) begin bad++; $display("FAIL reset_font_addr got=%h want=000", font_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0]  ra;
        logic [11:0] exp;
        int j;
        ra = 8'h66;
        write_buf(0, 8'h41);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) apply(i, 3, 1'b1, 1'(i % 2), 1'((i / 2) % 2));
            else idle();
            @(posedge clk); #1;
            if (i < 8) begin
                total++;
                if (font_addr !== 10'h20B) begin
                    bad++; $display("FAIL basic_font_addr px=%0d got=%h want=20B", i, font_addr);
                end
            end
            if (i >= 2) begin
                j = i - 2;
                exp = ra[7 - j] ? 12'hFFF : 12'h000;
                total++;
                if (rgb !== exp) begin bad++; $display("FAIL basic_rgb px=%0d got=%h want=%h", j, rgb, exp); end
                total++;
                if (hsync !== 1'(j % 2)) begin bad++; $display("FAIL basic_hsync px=%0d got=%b want=%0d", j, hsync, j % 2); end
                total++;
                if (vsync !== 1'((j / 2) % 2)) begin bad++; $display("FAIL basic_vsync px=%0d got=%b want=%0d", j, vsync, (j / 2) % 2); end
            end
        end
    endtask

    task automatic test_inverse();
        logic [11:0] exp;
        int j;
        write_buf(81, 8'hC1);
        for (int i = 0; i < 66; i++) begin
            if (i < 64) apply(8 + i % 8, 8 + i / 8, 1'b1, 1'b0, 1'b0);
            else idle();
            @(posedge clk); #1;
            if (i >= 2) begin
                j = i - 2;
                exp = pix(8'hC1, j % 8, j / 8, 1'b0);
                total++;
                if (rgb !== exp) begin bad++; $display("FAIL inverse_rgb x=%0d y=%0d got=%h want=%h", j % 8, j / 8, rgb, exp); end
            end
        end
    endtask

    task automatic test_cursor();
        logic [11:0] exp;
        logic        hit;
        int j;
        write_buf(2, 8'h43);
        cursor_en  = 1'b1;
        cursor_col = 7'd2;
        cursor_row = 6'd0;
        for (int f = 1; f <= 48; f++) begin
            hit = ((f % 32) < 16);
            for (int i = 0; i < 12; i++) begin
                if (i == 0) apply(0, 0, 1'b0, 1'b0, 1'b0);
                else if (i <= 8) apply(16 + i - 1, 7, 1'b1, 1'b0, 1'b0);
                else if (i == 9) apply(16, 6, 1'b1, 1'b0, 1'b0);
                else idle();
                @(posedge clk); #1;
                if (i >= 2) begin
                    j = i - 2;
                    if (j == 0) exp = 12'h000;
                    else if (j <= 8) exp = pix(8'h43, j - 1, 7, hit);
                    else exp = pix(8'h43, 0, 6, 1'b0);
                    total++;
                    if (rgb !== exp) begin bad++; $display("FAIL cursor_rgb frame=%0d item=%0d got=%h want=%h", f, j, rgb, exp); end
                end
            end
        end
    endtask

    task automatic test_blank();
        int          hv [4] = '{640, 3, 1, 1};
        int          vv [4] = '{3, 480, 3, 3};
        logic        von[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [11:0] exp[4] = '{12'h000, 12'h000, 12'h000, 12'hFFF};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) apply(hv[i], vv[i], von[i], 1'b0, 1'b0);
            else idle();
            @(posedge clk); #1;
            if (i >= 2) begin
                total++;
                if (rgb !== exp[i - 2]) begin bad++; $display("FAIL blank_rgb item=%0d got=%h want=%h", i - 2, rgb, exp[i - 2]); end
            end
        end
    endtask

    task automatic test_collision();
        write_buf(5, 8'h41);
        apply(43, 3, 1'b1, 1'b0, 1'b0);
        buf_waddr = 13'd5;
        buf_wdata = 8'h42;
        buf_we    = 1'b1;
        @(posedge clk); #1;
        buf_we = 1'b0;
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL collision_old got=%h want=000", rgb); end
        write_buf(4800, 8'h00);
        apply(43, 3, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        apply(1, 3, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL collision_new got=%h want=FFF", rgb); end
        @(posedge clk); #1;
        total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL oob_write_addr0 got=%h want=FFF", rgb); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp[3];
        logic        ehs[3] = '{1'b1, 1'b0, 1'b1};
        int j;
        exp[0] = pix(8'h41, 1, 3, 1'b0);
        exp[1] = pix(8'h43, 0, 7, 1'b1);
        exp[2] = pix(8'h43, 1, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(1, 3, 1'b1, 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL premid_rgb got=%h want=FFF", rgb); end
        total++; if (hsync !== 1'b1) begin bad++; $display("FAIL premid_hsync got=%b want=1", hsync); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL midrst_rgb got=%h want=000", rgb); end
        total++; if (hsync !== 1'b0) begin bad++; $display("FAIL midrst_hsync got=%b want=0", hsync); end
        total++; if (vsync !== 1'b0) begin bad++; $display("FAIL midrst_vsync got=%b want=0", vsync); end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) apply(1, 3, 1'b1, 1'b1, 1'b0);
            else if (i == 1) apply(16, 7, 1'b1, 1'b0, 1'b1);
            else if (i == 2) apply(17, 3, 1'b1, 1'b1, 1'b1);
            else idle();
            @(posedge clk); #1;
            if (i < 2) begin
                total++;
                if (rgb !== 12'h000 || hsync !== 1'b0) begin
                    bad++; $display("FAIL refill_cycle%0d got rgb=%h hs=%b want rgb=000 hs=0", i, rgb, hsync);
                end
            end else begin
                j = i - 2;
                total++;
                if (rgb !== exp[j]) begin bad++; $display("FAIL after_rst_rgb item=%0d got=%h want=%h", j, rgb, exp[j]); end
                total++;
                if (hsync !== ehs[j]) begin bad++; $display("FAIL after_rst_hsync item=%0d got=%b want=%b", j, hsync, ehs[j]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverse();
        test_cursor();
        test_blank();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
